// File: rtl/uart_module_rx.sv
// uart_module_rx: 8N1 UART receiver, mid-bit sampling, 1-cycle strobes per frame.
// Latency: rx_valid rises HALF_PERIOD + 9*BIT_PERIOD + 3 cycles after the rx_uart start-bit fall.
// Backpressure: none; rx_byte is held until the next good frame, so the consumer must take each strobe.
// Ports:
//   clk       - system clock, all logic on posedge
//   kill      - synchronous active-high reset, wins over every other event
//   rx_uart   - asynchronous serial line, idle high
//   rx_byte   - last good byte received
//   rx_valid  - 1-cycle pulse, rx_byte just updated by a frame with a good stop bit
//   frame_err - 1-cycle pulse, stop bit sampled low (rx_byte left untouched)
//   busy      - high while a frame is in progress (FSM not idle)

module uart_module_rx #(
  parameter int INPUT_CLK = 50000000,
  parameter int BAUD_RATE = 230400
) (
  input  logic       clk,
  input  logic       kill,
  input  logic       rx_uart,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_PERIOD  = INPUT_CLK / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNTR_WIDTH  = $clog2(BIT_PERIOD) + 1;

  localparam logic [CNTR_WIDTH-1:0] BIT_LAST  = CNTR_WIDTH'(BIT_PERIOD - 1);
  localparam logic [CNTR_WIDTH-1:0] HALF_LAST = CNTR_WIDTH'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic                  sync1_q,     sync1_d;
  logic                  sync2_q,     sync2_d;
  logic                  rx_d_q,      rx_d_d;
  logic [CNTR_WIDTH-1:0] cntr_q,      cntr_d;
  logic [2:0]            bit_idx_q,   bit_idx_d;
  logic [7:0]            shift_q,     shift_d;
  logic [7:0]            rx_byte_q,   rx_byte_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q,      busy_d;

  logic rx_s;
  logic fall;

  assign rx_s = sync2_q;
  // Edge, not level: a line parked low (break) never starts a frame.
  assign fall = rx_d_q & ~rx_s;

  always_comb begin
    sync1_d     = rx_uart;
    sync2_d     = sync1_q;
    rx_d_d      = sync2_q;
    state_d     = state_q;
    cntr_d      = cntr_q + CNTR_WIDTH'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cntr_d = '0;
        if (fall) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cntr_q == HALF_LAST) begin
          cntr_d = '0;
          // Line back high at mid start bit means it was a glitch.
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cntr_q == BIT_LAST) begin
          cntr_d    = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cntr_q == BIT_LAST) begin
          cntr_d = '0;
          // Return to idle at mid stop bit so an immediately following
          // start edge is not missed.
          state_d = ST_IDLE;
          if (rx_s) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cntr_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_d_q      <= 1'b1;
      cntr_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_d_q      <= rx_d_d;
      cntr_q      <= cntr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_module_rx.sv
// tb_uart_module_rx: drives serial frames into uart_module_rx and checks strobes and data.
// Latency: frames observed against an expected-event queue filled by the serial driver.
// Backpressure: not applicable; the receiver has no ready input.

module tb_uart_module_rx;

  // Shorter bit period than the production default keeps the run short;
  // every timing expectation below is derived from these values.
  localparam int  CLK_HZ = 50000000;
  localparam int  BAUD   = 1562500;
  localparam int  BIT    = CLK_HZ / BAUD;
  localparam int  HALF   = BIT / 2;
  localparam real TCLK   = 20.0;
  localparam real TBIT   = TCLK * BIT;

  logic       clk = 1'b0;
  logic       kill = 1'b1;
  logic       rx_uart = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_module_rx #(
    .INPUT_CLK (CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk       (clk),
    .kill      (kill),
    .rx_uart   (rx_uart),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: each sent frame pushes {is_err, byte}; strobes pop in order.
  logic [8:0] exp_q[$];
  logic [8:0] ev;
  logic [7:0] last_good = 8'h00;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         t_valid = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && frame_err === 1'b1) chk("both_strobes", 32'(frame_err), 0);
    if (rx_valid === 1'b1) begin
      n_valid++;
      t_valid = cyc;
      chk("valid_width", 32'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(exp_q.size()), 1);
      end else begin
        ev = exp_q.pop_front();
        chk("valid_kind", 32'(ev[8]), 0);
        chk("rx_byte", 32'(rx_byte), 32'(ev[7:0]));
        last_good = ev[7:0];
      end
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      chk("ferr_width", 32'(prev_err), 0);
      if (exp_q.size() == 0) begin
        chk("spurious_ferr", 32'(exp_q.size()), 1);
      end else begin
        ev = exp_q.pop_front();
        chk("ferr_kind", 32'(ev[8]), 1);
        chk("ferr_byte_hold", 32'(rx_byte), 32'(last_good));
      end
    end
    prev_valid = (rx_valid === 1'b1);
    prev_err   = (frame_err === 1'b1);
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input real tb, input bit expect_it);
    if (expect_it) exp_q.push_back({~stop, b});
    rx_uart = 1'b0;
    #(tb);
    for (int i = 0; i < 8; i++) begin
      rx_uart = b[i];
      #(tb);
    end
    rx_uart = stop;
    #(tb);
  endtask

  int n0_v, n0_e, t_fall, t_drop;
  logic [7:0] rb;

  initial begin
    // Reset state
    kill = 1'b1;
    rx_uart = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_byte", 32'(rx_byte), 0);
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_busy", 32'(busy), 0);
    kill = 1'b0;
    repeat (5) @(posedge clk);

    // 1: single frame, count and latency
    @(posedge clk);
    #1;
    t_fall = cyc;
    n0_v = n_valid; n0_e = n_ferr;
    send_frame(8'hA5, 1'b1, TBIT, 1'b1);
    #(2 * TBIT);
    chk("t1_valid_count", 32'(n_valid - n0_v), 1);
    chk("t1_ferr_count", 32'(n_ferr - n0_e), 0);
    chk("t1_rx_byte", 32'(rx_byte), 32'h A5);
    chk("t1_latency_lo", 32'(t_valid - t_fall >= HALF + 9 * BIT + 3), 1);
    chk("t1_latency_hi", 32'(t_valid - t_fall <= HALF + 9 * BIT + 5), 1);

    // 2: back-to-back frames without idle gap
    n0_v = n_valid;
    send_frame(8'h00, 1'b1, TBIT, 1'b1);
    send_frame(8'hFF, 1'b1, TBIT, 1'b1);
    #(2 * TBIT);
    chk("t2_valid_count", 32'(n_valid - n0_v), 2);
    chk("t2_rx_byte", 32'(rx_byte), 32'h FF);
    chk("t2_idle_busy", 32'(busy), 0);

    // 3: short low glitch is rejected at mid start bit
    n0_v = n_valid; n0_e = n_ferr;
    @(posedge clk);
    #1;
    t_fall = cyc;
    rx_uart = 1'b0;
    #(TCLK * (HALF / 3));
    rx_uart = 1'b1;
    chk("t3_busy_seen", 32'(busy), 1);
    t_drop = -1;
    for (int i = 0; i < 4 * BIT && t_drop < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) t_drop = cyc;
    end
    chk("t3_busy_dropped", 32'(t_drop >= 0), 1);
    chk("t3_busy_drop_time", 32'(t_drop - t_fall <= HALF + 5), 1);
    #(2 * TBIT);
    chk("t3_no_strobes", 32'((n_valid - n0_v) + (n_ferr - n0_e)), 0);

    // 4: bad stop bit, break, recovery
    n0_v = n_valid; n0_e = n_ferr;
    rb = rx_byte;
    send_frame(8'h3C, 1'b0, TBIT, 1'b1);
    #(20 * TBIT);
    rx_uart = 1'b1;
    chk("t4_ferr_count", 32'(n_ferr - n0_e), 1);
    chk("t4_byte_hold", 32'(rx_byte), 32'(rb));
    #(2 * TBIT);
    send_frame(8'h81, 1'b1, TBIT, 1'b1);
    #(2 * TBIT);
    chk("t4_valid_count", 32'(n_valid - n0_v), 1);
    chk("t4_ferr_total", 32'(n_ferr - n0_e), 1);
    chk("t4_rx_byte", 32'(rx_byte), 32'h 81);

    // 5: kill during data bit 4; bits 4..7 and stop are high so no false start follows
    n0_v = n_valid; n0_e = n_ferr;
    fork
      send_frame(8'hF0, 1'b1, TBIT, 1'b0);
      begin
        #(5.5 * TBIT);
        @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_kill_busy", 32'(busy), 0);
        chk("t5_kill_rx_byte", 32'(rx_byte), 0);
        chk("t5_kill_valid", 32'(rx_valid), 0);
        chk("t5_kill_ferr", 32'(frame_err), 0);
        kill = 1'b0;
        last_good = 8'h00;
      end
    join
    #(2 * TBIT);
    chk("t5_no_strobes", 32'((n_valid - n0_v) + (n_ferr - n0_e)), 0);
    send_frame(8'h5A, 1'b1, TBIT, 1'b1);
    #(2 * TBIT);
    chk("t5_valid_count", 32'(n_valid - n0_v), 1);
    chk("t5_rx_byte", 32'(rx_byte), 32'h 5A);

    // 6: random bytes at +2% and -2% baud, back-to-back
    for (int r = 0; r < 2; r++) begin
      n0_v = n_valid; n0_e = n_ferr;
      for (int k = 0; k < 48; k++) begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, (r == 0) ? TBIT / 1.02 : TBIT / 0.98, 1'b1);
      end
      #(2 * TBIT);
      chk("t6_valid_count", 32'(n_valid - n0_v), 48);
      chk("t6_ferr_count", 32'(n_ferr - n0_e), 0);
    end

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
